carpet_scroll_ctrl: RTL and testbench
=====================================

// Module: carpet_scroll_ctrl
// PURPOSE
//  Sequencer for the scrolling-carpet stripe renderer. Generates the 16-bit
//  carpet_count offset that the combinational stripe decoder subtracts from col.
//  carpet_count advances only on frame boundaries, so the picture never tears
//  mid-frame. Sits between the VGA timing block (frame_tick) and the renderer.
//  Owns start/pause/stop sequencing, speed selection and wrap at PERIOD.
// PARAMETERS
//  PERIOD     64  stripe pitch in pixels; carpet_count wraps modulo PERIOD
//  FRAME_DIV  2   frames per scroll step (1..255); 1 = step every frame
// PORTS
//  clk           in   1   pixel/system clock; all logic on rising edge
//  rst           in   1   synchronous, active-high reset
//  frame_tick    in   1   1-cycle pulse at vblank start, from VGA timing
//  start         in   1   1-cycle request: begin scrolling from offset 0
//  stop          in   1   1-cycle request: halt and clear offset
//  pause         in   1   level: freeze offset while high
//  speed         in   2   step select: 0->1, 1->2, 2->4, 3->8 px per step
//  carpet_count  out  16  current offset, 0..PERIOD-1, to stripe renderer
//  wrap_pulse    out  1   1-cycle pulse on the cycle carpet_count wraps
//  running       out  1   high in RUN
//  paused        out  1   high in PAUSE
// BEHAVIOUR
//  Reset: state=IDLE, carpet_count=0, frame divider=0, wrap_pulse=0,
//   running=0, paused=0. Reset mid-operation discards everything in 1 cycle.
//  States: IDLE, RUN, PAUSE (2-bit encoding).
//   IDLE : count held 0. start -> RUN (divider cleared).
//   RUN  : on frame_tick, divider++. At divider==FRAME_DIV-1: divider<=0, step.
//          pause high on a frame_tick -> PAUSE, no step that frame.
//          stop -> IDLE, count<=0 next cycle.
//   PAUSE: count and divider frozen. On frame_tick with pause low -> RUN;
//          first step no earlier than FRAME_DIV ticks later. stop -> IDLE.
//  Step: s = 1<<speed, speed sampled on the stepping frame_tick only.
//   sum = carpet_count + s; if sum >= PERIOD: count<=sum-PERIOD, wrap_pulse=1
//   in the same cycle the count is updated; else count<=sum. Arithmetic 16-bit,
//   no overflow for PERIOD<=32768.
//  Latency: carpet_count changes exactly 1 cycle after the stepping frame_tick;
//   constant for the rest of the frame.
//  Priority in the same cycle: rst > stop > start > pause > frame_tick step.
//   start while RUN/PAUSE: restart from 0 in RUN. stop in IDLE: no effect.
//   start and frame_tick together in IDLE: enter RUN; that tick is not counted.
//  Outputs registered; running/paused decode state directly (no glitch).
//  carpet_count never reaches PERIOD (renderer's ==PERIOD reset never fires).
// STRUCTURE
//  Shared package carpet_pkg: CARPET_PERIOD=64, state encodings
//   ST_IDLE=0, ST_RUN=1, ST_PAUSE=2, speed-to-step table.
//  One sub-module: frame_prescaler (frame_tick in, clear/enable in,
//   step_en out; 8-bit counter to FRAME_DIV-1). Top holds FSM + accumulator.
// TESTING
//  1 rst high 2 cycles, ticks applied -> count=0, running=0, no wrap_pulse.
//  2 FRAME_DIV=2, speed=0, start, 6 frame_ticks -> count 0,0,1,1,2,2,3 sequence
//    ends at 3; running=1.
//  3 count=62, speed=1 step -> count=0, wrap_pulse exactly 1 cycle; speed=3
//    from 56 -> 0 with wrap; speed=2 from 62 -> 2 with wrap.
//  4 pause high across 4 ticks -> count frozen, paused=1; release -> resumes
//    after FRAME_DIV ticks.
//  5 stop at count=40 -> IDLE, count=0 next cycle; stop+start same cycle ->
//    IDLE.
//  6 start coincident with frame_tick in IDLE -> tick ignored; rst mid-RUN at
//    count=17 -> all outputs reset values next cycle.

Source files
------------

// File: rtl/carpet_pkg.sv
// Shared definitions for the scrolling-carpet sequencer: stripe pitch, FSM encoding, speed table.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package carpet_pkg;

    localparam int CARPET_PERIOD = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Pixels advanced per scroll step for each speed code.
    function automatic logic [15:0] speed_step(input logic [1:0] speed);
        logic [15:0] s;
        case (speed)
            2'd0:    s = 16'd1;
            2'd1:    s = 16'd2;
            2'd2:    s = 16'd4;
            default: s = 16'd8;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/frame_prescaler.sv
// Divides frame_tick by FRAME_DIV, emitting step_en on the tick that completes a period.
// Latency: step_en is combinational from frame_tick; counter updates next cycle.
// Backpressure: none; enable low freezes the count, clear forces it to zero.
module frame_prescaler #(
    parameter int FRAME_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic clear,
    input  logic enable,
    output logic step_en
);

    localparam logic [7:0] LAST = 8'(FRAME_DIV - 1);

    logic [7:0] div_cnt;

    assign step_en = enable && frame_tick && !clear && (div_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= 8'd0;
        end else if (clear) begin
            div_cnt <= 8'd0;
        end else if (enable && frame_tick) begin
            if (div_cnt == LAST) begin
                div_cnt <= 8'd0;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/carpet_scroll_ctrl.sv
// Start/pause/stop sequencer producing the carpet scroll offset, stepping only on frame boundaries.
// Latency: carpet_count and wrap_pulse update 1 cycle after the stepping frame_tick.
// Backpressure: none; pause freezes the offset, stop clears it.
module carpet_scroll_ctrl
    import carpet_pkg::*;
#(
    parameter int PERIOD    = CARPET_PERIOD,
    parameter int FRAME_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic [1:0]  speed,
    output logic [15:0] carpet_count,
    output logic        wrap_pulse,
    output logic        running,
    output logic        paused
);

    localparam logic [15:0] PERIOD_W = 16'(PERIOD);

    state_t      state;
    logic        resume;
    logic        pre_clear;
    logic        pre_enable;
    logic        step_en;
    logic [15:0] sum;

    // Resuming restarts the frame divider so the first step is a full FRAME_DIV ticks away.
    assign resume     = (state == ST_PAUSE) && frame_tick && !pause;
    assign pre_clear  = stop || start || resume || (state == ST_IDLE);
    assign pre_enable = (state == ST_RUN) && !pause;
    assign sum        = carpet_count + speed_step(speed);

    assign running = (state == ST_RUN);
    assign paused  = (state == ST_PAUSE);

    frame_prescaler #(
        .FRAME_DIV (FRAME_DIV)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .clear      (pre_clear),
        .enable     (pre_enable),
        .step_en    (step_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            carpet_count <= 16'd0;
            wrap_pulse   <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (stop) begin
                state        <= ST_IDLE;
                carpet_count <= 16'd0;
            end else if (start) begin
                state        <= ST_RUN;
                carpet_count <= 16'd0;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (frame_tick && pause) begin
                            state <= ST_PAUSE;
                        end else if (step_en) begin
                            if (sum >= PERIOD_W) begin
                                carpet_count <= sum - PERIOD_W;
                                wrap_pulse   <= 1'b1;
                            end else begin
                                carpet_count <= sum;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (resume) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_IDLE: begin
                        carpet_count <= 16'd0;
                    end
                    default: begin
                        state        <= ST_IDLE;
                        carpet_count <= 16'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_carpet_scroll_ctrl.sv
// Bench for carpet_scroll_ctrl: directed vectors, a tick-counting reference model checked every cycle,
// plus literal expectations at key points.
module tb_carpet_scroll_ctrl;

    localparam int FD  = 2;
    localparam int PER = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic [15:0] carpet_count;
    logic        wrap_pulse;
    logic        running;
    logic        paused;

    int errors = 0;
    int checks = 0;

    // Model: 0 idle, 1 run, 2 pause; ticks counted since the last start or resume.
    int ms = 0;
    int mc = 0;
    int mt = 0;
    int mw = 0;

    int t2_exp [6] = '{0, 1, 1, 2, 2, 3};

    always #5 clk = ~clk;

    carpet_scroll_ctrl #(
        .PERIOD    (PER),
        .FRAME_DIV (FD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .start        (start),
        .stop         (stop),
        .pause        (pause),
        .speed        (speed),
        .carpet_count (carpet_count),
        .wrap_pulse   (wrap_pulse),
        .running      (running),
        .paused       (paused)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            ms = 0; mc = 0; mt = 0; mw = 0;
        end else begin
            mw = 0;
            if (stop) begin
                ms = 0; mc = 0; mt = 0;
            end else if (start) begin
                ms = 1; mc = 0; mt = 0;
            end else if (ms == 1 && frame_tick) begin
                if (pause) begin
                    ms = 2;
                end else begin
                    mt = mt + 1;
                    if (mt % FD == 0) begin
                        mc = mc + (1 << speed);
                        if (mc >= PER) begin
                            mc = mc - PER;
                            mw = 1;
                        end
                    end
                end
            end else if (ms == 2 && frame_tick && !pause) begin
                ms = 1; mt = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_count", int'(carpet_count), mc);
        chk("cmp_wrap", int'(wrap_pulse), mw);
        chk("cmp_running", int'(running), int'(ms == 1));
        chk("cmp_paused", int'(paused), int'(ms == 2));
    end

    task automatic cyc(input logic ft, input logic sta, input logic sto);
        frame_tick = ft;
        start = sta;
        stop = sto;
        @(negedge clk);
        frame_tick = 1'b0;
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic frame();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Two ticks; the second is the stepping tick and the call returns right after it.
    task automatic do_step(input logic [1:0] sp);
        speed = sp;
        frame();
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic run_to_62();
        cyc(1'b0, 1'b1, 1'b0);
        repeat (7) do_step(2'd3);
        do_step(2'd2);
        do_step(2'd1);
    endtask

    initial begin
        // Reset held with ticks arriving
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("t1_count", int'(carpet_count), 0);
        chk("t1_running", int'(running), 0);
        chk("t1_wrap", int'(wrap_pulse), 0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // Basic scroll, speed 0
        speed = 2'd0;
        cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            frame();
            chk("t2_seq", int'(carpet_count), t2_exp[i]);
        end
        chk("t2_running", int'(running), 1);

        // Wrap cases
        cyc(1'b0, 1'b1, 1'b0);
        repeat (7) do_step(2'd3);
        chk("t3_at56", int'(carpet_count), 56);
        do_step(2'd3);
        chk("t3_s3_count", int'(carpet_count), 0);
        chk("t3_s3_wrap", int'(wrap_pulse), 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t3_s3_wrap_off", int'(wrap_pulse), 0);

        run_to_62();
        chk("t3_at62", int'(carpet_count), 62);
        do_step(2'd1);
        chk("t3_s1_count", int'(carpet_count), 0);
        chk("t3_s1_wrap", int'(wrap_pulse), 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t3_s1_wrap_off", int'(wrap_pulse), 0);

        run_to_62();
        do_step(2'd2);
        chk("t3_s2_count", int'(carpet_count), 2);
        chk("t3_s2_wrap", int'(wrap_pulse), 1);
        cyc(1'b0, 1'b0, 1'b0);

        // Pause across four ticks, then resume
        pause = 1'b1;
        repeat (4) frame();
        chk("t4_paused", int'(paused), 1);
        chk("t4_frozen", int'(carpet_count), 2);
        pause = 1'b0;
        frame();
        chk("t4_resumed", int'(running), 1);
        chk("t4_resume_tick", int'(carpet_count), 2);
        frame();
        chk("t4_first_tick", int'(carpet_count), 2);
        frame();
        chk("t4_first_step", int'(carpet_count), 6);

        // Stop behaviour
        cyc(1'b0, 1'b1, 1'b0);
        repeat (5) do_step(2'd3);
        chk("t5_at40", int'(carpet_count), 40);
        cyc(1'b0, 1'b0, 1'b1);
        chk("t5_stop_count", int'(carpet_count), 0);
        chk("t5_stop_running", int'(running), 0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("t5_stopstart_run", int'(running), 0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("t5_stopstart_idle", int'(running), 0);

        // Start coincident with tick, then reset mid-run
        cyc(1'b1, 1'b1, 1'b0);
        chk("t6_running", int'(running), 1);
        speed = 2'd0;
        frame();
        chk("t6_tick_ignored", int'(carpet_count), 0);
        frame();
        chk("t6_first_step", int'(carpet_count), 1);
        do_step(2'd3);
        do_step(2'd3);
        chk("t6_at17", int'(carpet_count), 17);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("t6_rst_count", int'(carpet_count), 0);
        chk("t6_rst_running", int'(running), 0);
        chk("t6_rst_paused", int'(paused), 0);
        chk("t6_rst_wrap", int'(wrap_pulse), 0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
